fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, is the instruction word presented to ID during a bubble.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hazard hold; freeze PC and IF/ID register.
REQ-006 flush  input  1  branch taken in ID; redirect fetch and squash the IF/ID contents.
REQ-007 branch_target  input  32  redirect address, valid when flush=1.
REQ-008 imem_addr  output  32  byte address to instruction memory; equals PC.
REQ-009 imem_enable  output  1  instruction memory read enable.
REQ-010 imem_data  input  32  instruction word returned combinationally in the same cycle.
REQ-011 ID_instr  output  32  registered instruction for the control unit.
REQ-012 ID_pc4  output  32  registered PC+4 of ID_instr, for branch-and-link and target math.
REQ-013 ID_valid  output  1  1 = ID_instr is a real fetched instruction; 0 = bubble.
REQ-014 fetch_count  output  32  number of instructions accepted into IF/ID since reset; saturates at 32'hFFFF_FFFF.

Function
REQ-015 FSM states are S_RESET, S_RUN and S_HOLD.
REQ-016 In S_RESET: imem_enable=0, no IF/ID load; the next state is S_RUN unless reset=1.
REQ-017 In S_RUN, when stall=0 and flush=0: imem_enable=1; on the edge, IF/ID<={imem_data, PC+4, valid=1}, PC<=PC+4 and fetch_count increments.
REQ-018 In S_RUN, when stall=1 and flush=0: PC and IF/ID hold and the next state is S_HOLD.
REQ-019 In S_HOLD: imem_enable=1 and PC and IF/ID hold while stall=1; when stall=0 the instruction at PC is loaded per REQ-017 and the next state is S_RUN.
REQ-020 When flush=1 in S_RUN or S_HOLD: PC<={branch_target[31:2],2'b00}, IF/ID<={NOP_INSTR, 32'h0, valid=0}, fetch_count holds and the next state is S_RUN.
REQ-021 When flush=1 and stall=1 in the same cycle, flush takes priority and stall is ignored for that cycle.
REQ-022 PC is always word-aligned; PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000) with no error flag.
REQ-023 imem_addr equals PC combinationally in every state.
REQ-024 Fetch latency is 1 cycle: an instruction presented at PC in cycle n appears on ID_instr after edge n.
REQ-025 fetch_count does not wrap; at 32'hFFFF_FFFF it holds at that value.
REQ-026 No output depends combinationally on stall or flush except via registered state; imem_addr depends only on PC.

Reset
REQ-027 When reset=1 at an edge: PC<=RESET_PC, ID_instr<=NOP_INSTR, ID_pc4<=0, ID_valid<=0, fetch_count<=0 and state<=S_RESET.
REQ-028 Reset overrides stall and flush in the same cycle, including mid-stall and mid-flush.
REQ-029 While reset=1, imem_enable=0.

Structure
REQ-030 The shared pipeline package holds the state encoding (S_RESET/S_RUN/S_HOLD), NOP_INSTR, the word-alignment mask and the instruction width of 32.
REQ-031 The IF/ID register (instr, pc4, valid, with load/squash controls) is a single sub-module named if_id_reg; the PC, FSM and counter live in fetch_stage.

Verification
REQ-032 The bench shall cover reset: with reset held 2 cycles then released, imem_addr=0, imem_enable=0 for 1 cycle, and ID_valid=0 until the first load.
REQ-033 The bench shall cover sequential fetch: memory returns 32'hE3A01005 at 0x0 and 32'hE2811001 at 0x4; ID_instr/ID_pc4 are E3A01005/0x4 and then E2811001/0x8, with fetch_count=2.
REQ-034 The bench shall cover stall: stall=1 for 3 cycles at PC=0x8; PC and ID outputs are frozen, and the fetch at 0x8 completes on the cycle after release.
REQ-035 The bench shall cover flush: flush=1 with branch_target=0x42; the next cycle gives PC=0x40, ID_valid=0 and ID_instr=NOP_INSTR, with fetch_count unchanged.
REQ-036 The bench shall cover simultaneous flush and stall: flush=1, stall=1 and branch_target=0x20 give PC=0x20 and state S_RUN.
REQ-037 The bench shall cover wrap: with RESET_PC=32'hFFFF_FFFC, one fetch gives ID_pc4=0 and PC=0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: state encoding, widths,
// bubble instruction and PC word-alignment helper.
package fetch_stage_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [INSTR_W-1:0] NOP_INSTR       = 32'h0000_0000;
  localparam logic [ADDR_W-1:0]  WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  // Force an address onto a word boundary.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures a fetched instruction and its PC+4,
// or squashes to a bubble; holds when neither load nor squash is asserted.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_squash,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [ADDR_W-1:0]  i_pc4,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc4,
  output logic               o_valid
);

  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc4;
  logic               r_valid;

  // Squash wins over load so a redirect can never leak a wrong-path word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr <= NOP_INSTR;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (i_squash) begin
      r_instr <= NOP_INSTR;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc4   <= i_pc4;
      r_valid <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_pc4   = r_pc4;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, run/hold/reset FSM, saturating fetch
// counter and the IF/ID pipeline register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  RESET_PC  = 32'h0000_0000,
  parameter logic [INSTR_W-1:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_enable,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] ID_instr,
  output logic [ADDR_W-1:0]  ID_pc4,
  output logic               ID_valid,
  output logic [31:0]        fetch_count
);

  localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

  fetch_state_e      r_state;
  fetch_state_e      w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic [ADDR_W-1:0] w_pc4;
  logic [31:0]       r_count;
  logic              w_load;
  logic              w_squash;
  logic              w_count_inc;

  // 32-bit add wraps naturally from 0xFFFF_FFFC to 0.
  assign w_pc4 = ADDR_W'(r_pc + 32'd4);

  // Next-state and datapath control; flush outranks stall.
  always_comb begin
    w_next_state = r_state;
    w_pc_next    = r_pc;
    w_load       = 1'b0;
    w_squash     = 1'b0;
    w_count_inc  = 1'b0;
    case (r_state)
      S_RESET: begin
        w_next_state = S_RUN;
      end
      S_RUN, S_HOLD: begin
        if (flush) begin
          w_pc_next    = word_align(branch_target);
          w_squash     = 1'b1;
          w_next_state = S_RUN;
        end else if (stall) begin
          w_next_state = S_HOLD;
        end else begin
          w_pc_next    = w_pc4;
          w_load       = 1'b1;
          w_count_inc  = 1'b1;
          w_next_state = S_RUN;
        end
      end
      default: begin
        w_next_state = S_RESET;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RESET;
      r_pc    <= word_align(RESET_PC);
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_pc_next;
      if (w_count_inc && (r_count != COUNT_MAX)) begin
        r_count <= r_count + 32'd1;
      end
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load),
    .i_squash (w_squash),
    .i_instr  (imem_data),
    .i_pc4    (w_pc4),
    .o_instr  (ID_instr),
    .o_pc4    (ID_pc4),
    .o_valid  (ID_valid)
  );

  // Memory is only enabled once out of reset; address tracks PC alone.
  assign imem_addr   = r_pc;
  assign imem_enable = (r_state != S_RESET) && !reset;
  assign fetch_count = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, sequential fetch, stall, flush,
// flush+stall, reset mid-stall and PC wrap on a second instance.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk;
  logic        reset, stall, flush;
  logic [31:0] branch_target;
  logic [31:0] imem_addr, imem_data, ID_instr, ID_pc4, fetch_count;
  logic        imem_enable, ID_valid;

  logic        w_reset;
  logic [31:0] w_imem_addr, w_imem_data, w_ID_instr, w_ID_pc4, w_fetch_count;
  logic        w_imem_enable, w_ID_valid;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'hE3A0_1005;
      32'h0000_0004: return 32'hE281_1001;
      32'h0000_0008: return 32'hE080_0001;
      32'h0000_0020: return 32'hE1A0_0000;
      32'h0000_0040: return 32'hEAFF_FFFE;
      default:       return 32'hDEAD_0000 ^ a;
    endcase
  endfunction

  assign imem_data   = mem(imem_addr);
  assign w_imem_data = mem(w_imem_addr);

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_enable   (imem_enable),
    .imem_data     (imem_data),
    .ID_instr      (ID_instr),
    .ID_pc4        (ID_pc4),
    .ID_valid      (ID_valid),
    .fetch_count   (fetch_count)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk           (clk),
    .reset         (w_reset),
    .stall         (1'b0),
    .flush         (1'b0),
    .branch_target (32'h0),
    .imem_addr     (w_imem_addr),
    .imem_enable   (w_imem_enable),
    .imem_data     (w_imem_data),
    .ID_instr      (w_ID_instr),
    .ID_pc4        (w_ID_pc4),
    .ID_valid      (w_ID_valid),
    .fetch_count   (w_fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; w_reset = 1'b1;
    stall = 1'b0; flush = 1'b0; branch_target = 32'h0;

    // Reset held for two edges
    tick();
    check("rst_addr", imem_addr, 32'h0);
    check("rst_en", 32'(imem_enable), 32'h0);
    check("rst_valid", 32'(ID_valid), 32'h0);
    check("rst_count", fetch_count, 32'h0);
    check("rst_instr", ID_instr, 32'h0);
    tick();
    reset = 1'b0; w_reset = 1'b0;
    #1;
    check("sreset_en", 32'(imem_enable), 32'h0);
    check("sreset_addr", imem_addr, 32'h0);
    check("sreset_valid", 32'(ID_valid), 32'h0);
    check("wrap_rst_addr", w_imem_addr, 32'hFFFF_FFFC);

    // S_RESET -> S_RUN, no load
    tick();
    check("run_en", 32'(imem_enable), 32'h1);
    check("run_valid", 32'(ID_valid), 32'h0);
    check("run_addr", imem_addr, 32'h0);
    check("run_count", fetch_count, 32'h0);

    // Sequential fetch
    tick();
    check("f0_instr", ID_instr, 32'hE3A0_1005);
    check("f0_pc4", ID_pc4, 32'h4);
    check("f0_valid", 32'(ID_valid), 32'h1);
    check("f0_addr", imem_addr, 32'h4);
    check("f0_count", fetch_count, 32'h1);
    check("wrap_pc4", w_ID_pc4, 32'h0);
    check("wrap_addr", w_imem_addr, 32'h0);
    check("wrap_valid", 32'(w_ID_valid), 32'h1);
    check("wrap_count", w_fetch_count, 32'h1);
    tick();
    check("f1_instr", ID_instr, 32'hE281_1001);
    check("f1_pc4", ID_pc4, 32'h8);
    check("f1_count", fetch_count, 32'h2);
    check("f1_addr", imem_addr, 32'h8);

    // Stall three cycles at PC=0x8
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_addr", imem_addr, 32'h8);
      check("stall_instr", ID_instr, 32'hE281_1001);
      check("stall_pc4", ID_pc4, 32'h8);
      check("stall_count", fetch_count, 32'h2);
      check("stall_en", 32'(imem_enable), 32'h1);
    end
    stall = 1'b0;
    tick();
    check("rel_instr", ID_instr, 32'hE080_0001);
    check("rel_pc4", ID_pc4, 32'hC);
    check("rel_addr", imem_addr, 32'hC);
    check("rel_count", fetch_count, 32'h3);

    // Flush to misaligned target 0x42
    flush = 1'b1; branch_target = 32'h42;
    tick();
    flush = 1'b0;
    check("fl_addr", imem_addr, 32'h40);
    check("fl_valid", 32'(ID_valid), 32'h0);
    check("fl_instr", ID_instr, 32'h0);
    check("fl_pc4", ID_pc4, 32'h0);
    check("fl_count", fetch_count, 32'h3);
    tick();
    check("post_fl_instr", ID_instr, 32'hEAFF_FFFE);
    check("post_fl_pc4", ID_pc4, 32'h44);
    check("post_fl_count", fetch_count, 32'h4);

    // Flush and stall together: flush wins
    flush = 1'b1; stall = 1'b1; branch_target = 32'h20;
    tick();
    flush = 1'b0; stall = 1'b0;
    check("fs_addr", imem_addr, 32'h20);
    check("fs_valid", 32'(ID_valid), 32'h0);
    check("fs_state", 32'(dut.r_state), 32'(S_RUN));
    check("fs_count", fetch_count, 32'h4);
    tick();
    check("post_fs_instr", ID_instr, 32'hE1A0_0000);
    check("post_fs_pc4", ID_pc4, 32'h24);
    check("post_fs_count", fetch_count, 32'h5);

    // Reset mid-stall with flush also asserted
    stall = 1'b1;
    tick();
    check("hold_state", 32'(dut.r_state), 32'(S_HOLD));
    reset = 1'b1; flush = 1'b1; branch_target = 32'h80;
    tick();
    check("mrst_addr", imem_addr, 32'h0);
    check("mrst_valid", 32'(ID_valid), 32'h0);
    check("mrst_count", fetch_count, 32'h0);
    check("mrst_en", 32'(imem_enable), 32'h0);
    check("mrst_state", 32'(dut.r_state), 32'(S_RESET));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
